id_ex_reg: RTL and testbench

ID/EX pipeline register of the five-stage pipeline CPU. It sits directly downstream of the decode-stage immediate extender and register-file read. It captures the 32-bit extended immediate, the operands, the instruction and the hazard bookkeeping at the clock edge, and presents them to the EX stage. It supports hold (stall), bubble insertion (flush) and saturating Tnew aging, and it counts inserted bubbles for performance debug.

---
 rtl/id_ex_reg.sv | 86 ++++++++
 tb/tb_id_ex_reg.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register.
// Captures the decode-stage instruction, PC, forwarded operands, extended
// immediate and hazard bookkeeping (destination, Tnew) at the rising edge and
// presents them to the EX stage. Supports hold (stall), bubble insertion
// (flush), saturating Tnew aging and a saturating bubble counter.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   en             1 = load from D, 0 = hold
//   clr            1 = insert bubble (overrides en = 0)
//   *_D            decode-stage inputs (instr, pc, rs, rt, ext, a3, tnew)
//   *_E            registered EX-stage copies
//   valid_E        E holds a real instruction
//   fwd_ok_E       result in E may be forwarded (combinational from E regs)
//   bubble_cnt     bubbles inserted since reset, saturating

module id_ex_reg #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [31:0]      instr_D,
    input  logic [31:0]      pc_D,
    input  logic [31:0]      rs_D,
    input  logic [31:0]      rt_D,
    input  logic [31:0]      ext_D,
    input  logic [4:0]       a3_D,
    input  logic [1:0]       tnew_D,
    output logic [31:0]      instr_E,
    output logic [31:0]      pc_E,
    output logic [31:0]      rs_E,
    output logic [31:0]      rt_E,
    output logic [31:0]      ext_E,
    output logic [4:0]       a3_E,
    output logic [1:0]       tnew_E,
    output logic             valid_E,
    output logic             fwd_ok_E,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [1:0] tnew_aged;

    // One cycle passes between D and E, so Tnew drops by one, floored at 0.
    assign tnew_aged = (tnew_D == 2'd0) ? 2'd0 : (tnew_D - 2'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_E    <= '0;
            pc_E       <= '0;
            rs_E       <= '0;
            rt_E       <= '0;
            ext_E      <= '0;
            a3_E       <= '0;
            tnew_E     <= '0;
            valid_E    <= 1'b0;
            bubble_cnt <= '0;
        end else if (clr) begin
            instr_E <= '0;
            // Bubble keeps the stalled instruction's PC for exception reporting.
            pc_E    <= pc_D;
            rs_E    <= '0;
            rt_E    <= '0;
            ext_E   <= '0;
            a3_E    <= '0;
            tnew_E  <= '0;
            valid_E <= 1'b0;
            if (bubble_cnt != {CNT_W{1'b1}}) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end else if (en) begin
            instr_E <= instr_D;
            pc_E    <= pc_D;
            rs_E    <= rs_D;
            rt_E    <= rt_D;
            ext_E   <= ext_D;
            a3_E    <= a3_D;
            tnew_E  <= tnew_aged;
            valid_E <= 1'b1;
        end
    end

    assign fwd_ok_E = valid_E & (a3_E != 5'd0) & (tnew_E == 2'd0);

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

    logic        clk;
    logic        reset;
    logic        en;
    logic        clr;
    logic [31:0] instr_D, pc_D, rs_D, rt_D, ext_D;
    logic [4:0]  a3_D;
    logic [1:0]  tnew_D;

    logic [31:0] instr_E, pc_E, rs_E, rt_E, ext_E;
    logic [4:0]  a3_E;
    logic [1:0]  tnew_E;
    logic        valid_E, fwd_ok_E;
    logic [15:0] bubble_cnt;

    logic [31:0] instr_E2, pc_E2, rs_E2, rt_E2, ext_E2;
    logic [4:0]  a3_E2;
    logic [1:0]  tnew_E2;
    logic        valid_E2, fwd_ok_E2;
    logic [1:0]  bubble_cnt2;

    int total = 0;
    int bad   = 0;

    id_ex_reg #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr),
        .instr_D(instr_D), .pc_D(pc_D), .rs_D(rs_D), .rt_D(rt_D),
        .ext_D(ext_D), .a3_D(a3_D), .tnew_D(tnew_D),
        .instr_E(instr_E), .pc_E(pc_E), .rs_E(rs_E), .rt_E(rt_E),
        .ext_E(ext_E), .a3_E(a3_E), .tnew_E(tnew_E), .valid_E(valid_E),
        .fwd_ok_E(fwd_ok_E), .bubble_cnt(bubble_cnt)
    );

    // Narrow-counter instance sharing the same inputs, for saturation.
    id_ex_reg #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .en(en), .clr(clr),
        .instr_D(instr_D), .pc_D(pc_D), .rs_D(rs_D), .rt_D(rt_D),
        .ext_D(ext_D), .a3_D(a3_D), .tnew_D(tnew_D),
        .instr_E(instr_E2), .pc_E(pc_E2), .rs_E(rs_E2), .rt_E(rt_E2),
        .ext_E(ext_E2), .a3_E(a3_E2), .tnew_E(tnew_E2), .valid_E(valid_E2),
        .fwd_ok_E(fwd_ok_E2), .bubble_cnt(bubble_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr, pc, rs, rt, ext;
        logic [4:0]  a3;
        logic [1:0]  tnew;
        logic        valid, fwd;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t sb_q[$];
    exp_t m;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, advance the reference model, push the
    // expectation, then pop and compare after the edge.
    task automatic step(input logic r, input logic c, input logic e,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] ext, input logic [4:0] a3,
                        input logic [1:0] tn);
        exp_t x;
        @(negedge clk);
        reset = r; clr = c; en = e;
        instr_D = ins; pc_D = pc; rs_D = rs; rt_D = rt; ext_D = ext;
        a3_D = a3; tnew_D = tn;
        if (r) begin
            m.instr = 0; m.pc = 0; m.rs = 0; m.rt = 0; m.ext = 0;
            m.a3 = 0; m.tnew = 0; m.valid = 0; m.cnt = 0; m.cnt2 = 0;
        end else if (c) begin
            m.instr = 0; m.pc = pc; m.rs = 0; m.rt = 0; m.ext = 0;
            m.a3 = 0; m.tnew = 0; m.valid = 0;
            if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
            if (m.cnt2 != 2'd3) m.cnt2 = m.cnt2 + 2'd1;
        end else if (e) begin
            m.instr = ins; m.pc = pc; m.rs = rs; m.rt = rt; m.ext = ext;
            m.a3 = a3; m.valid = 1;
            case (tn)
                2'd0: m.tnew = 2'd0;
                2'd1: m.tnew = 2'd0;
                2'd2: m.tnew = 2'd1;
                default: m.tnew = 2'd2;
            endcase
        end
        m.fwd = m.valid && (m.a3 != 0) && (m.tnew == 0);
        sb_q.push_back(m);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        check_val("instr_E", instr_E, x.instr);
        check_val("pc_E", pc_E, x.pc);
        check_val("rs_E", rs_E, x.rs);
        check_val("rt_E", rt_E, x.rt);
        check_val("ext_E", ext_E, x.ext);
        check_val("a3_E", 32'(a3_E), 32'(x.a3));
        check_val("tnew_E", 32'(tnew_E), 32'(x.tnew));
        check_val("valid_E", 32'(valid_E), 32'(x.valid));
        check_val("fwd_ok_E", 32'(fwd_ok_E), 32'(x.fwd));
        check_val("bubble_cnt", 32'(bubble_cnt), 32'(x.cnt));
        check_val("bubble_cnt_w2", 32'(bubble_cnt2), 32'(x.cnt2));
        check_val("pc_E_w2", pc_E2, x.pc);
        check_val("fwd_ok_E_w2", 32'(fwd_ok_E2), 32'(x.fwd));
    endtask

    initial begin
        m = '{default: '0};
        reset = 1; clr = 0; en = 1;
        instr_D = 32'hFFFF_FFFF; pc_D = 32'h1111_1111; rs_D = 32'h2222_2222;
        rt_D = 32'h3333_3333; ext_D = 32'h4444_4444; a3_D = 5'd7; tnew_D = 2'd2;

        // Reset with nonzero D inputs.
        step(1, 0, 1, 32'hFFFF_FFFF, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 5'd7, 2'd2);
        step(1, 0, 1, 32'hAAAA_AAAA, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888, 5'd31, 2'd3);
        check_val("reset_fwd", 32'(fwd_ok_E), 32'd0);
        check_val("reset_cnt", 32'(bubble_cnt), 32'd0);

        // Load with Tnew aging.
        step(0, 0, 1, 32'h3C01_1234, 32'h0000_3000, 32'h0, 32'h0, 32'h1234_0000, 5'd1, 2'd2);
        check_val("lui_ext", ext_E, 32'h1234_0000);
        check_val("lui_tnew", 32'(tnew_E), 32'd1);
        check_val("lui_fwd", 32'(fwd_ok_E), 32'd0);
        step(0, 0, 1, 32'h0022_0821, 32'h0000_3004, 32'h5, 32'h6, 32'hFFFF_FFFC, 5'd1, 2'd0);
        check_val("tnew0_fwd", 32'(fwd_ok_E), 32'd1);
        step(0, 0, 1, 32'h8C22_0004, 32'h0000_3008, 32'h9, 32'hA, 32'h0000_0004, 5'd2, 2'd3);
        step(0, 0, 1, 32'h0000_0000, 32'h0000_300C, 32'h1, 32'h2, 32'h0000_0001, 5'd3, 2'd1);

        // Hold.
        step(0, 0, 1, 32'h0043_2020, 32'h0000_3010, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 5'd4, 2'd2);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 32'h1000_0000 + 32'(i), 32'h0000_4000 + 32'(4*i), 32'h0BAD_0000 + 32'(i),
                 32'hC0DE_0000, 32'h0000_00FF, 5'd9, 2'd3);
        check_val("hold_rs", rs_E, 32'hDEAD_BEEF);
        check_val("hold_tnew", 32'(tnew_E), 32'd1);
        step(0, 0, 1, 32'h2084_0001, 32'h0000_3014, 32'hCAFE_F00D, 32'h0, 32'h1, 5'd4, 2'd1);
        check_val("resume_rs", rs_E, 32'hCAFE_F00D);

        // Bubbles; narrow counter must read 1,2,3,3,3.
        step(0, 1, 0, 32'h1234_5678, 32'h0000_3008, 32'h77, 32'h88, 32'h99, 5'd5, 2'd2);
        check_val("bub_pc", pc_E, 32'h0000_3008);
        check_val("bub_cnt1", 32'(bubble_cnt), 32'd1);
        check_val("sat_1", 32'(bubble_cnt2), 32'd1);
        step(0, 1, 1, 32'h1, 32'h0000_300C, 32'h1, 32'h1, 32'h1, 5'd1, 2'd1);
        check_val("sat_2", 32'(bubble_cnt2), 32'd2);
        step(0, 1, 0, 32'h2, 32'h0000_3010, 32'h2, 32'h2, 32'h2, 5'd2, 2'd2);
        check_val("sat_3", 32'(bubble_cnt2), 32'd3);
        step(0, 1, 1, 32'h3, 32'h0000_3014, 32'h3, 32'h3, 32'h3, 5'd3, 2'd3);
        check_val("bub_cnt4", 32'(bubble_cnt), 32'd4);
        check_val("sat_4", 32'(bubble_cnt2), 32'd3);
        step(0, 1, 1, 32'h4, 32'h0000_3018, 32'h4, 32'h4, 32'h4, 5'd4, 2'd0);
        check_val("sat_5", 32'(bubble_cnt2), 32'd3);

        // Zero destination never forwards.
        step(0, 0, 1, 32'h0000_0000, 32'h0000_301C, 32'h1, 32'h2, 32'h3, 5'd0, 2'd0);
        check_val("a3zero_fwd", 32'(fwd_ok_E), 32'd0);

        // Reset and clr together: reset wins, counter cleared.
        step(1, 1, 1, 32'h5, 32'h0000_3020, 32'h5, 32'h5, 32'h5, 5'd5, 2'd0);
        check_val("rstclr_cnt", 32'(bubble_cnt), 32'd0);
        check_val("rstclr_pc", pc_E, 32'd0);

        // Random mix.
        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                 $urandom, $urandom, $urandom, $urandom, $urandom,
                 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
